// File: rtl/crossbar_seq_pkg.sv
// Shared types and defaults for the crossbar route sequencer.
//   state_e  : sequencer FSM states (IDLE, SETUP, XFER)
//   entry_t  : queued request layout {dest, data} at the default widths;
//              the FIFO stores entries flattened in this same field order
//   cnt_w()  : width of an occupancy counter able to hold 0..depth
// Optional feature macro used by the block: CROSSBAR_SEQ_BCAST_EN.
package crossbar_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_NOUT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_NOUT-1:0]  dest;
    logic [DEF_WIDTH-1:0] data;
  } entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/crossbar_seq_fifo.sv
// Request FIFO for the crossbar route sequencer.
// Registered storage: an entry written on edge N is visible at head on
// cycle N+1. Exposes head and head+1 so the sequencer can decide, on the
// pop cycle, whether the next transfer needs a new crossbar setting.
// Ports:
//   clock, reset     : clock, synchronous active-low reset
//   push, push_data  : write one entry (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   head, head1      : entries at read pointer and read pointer + 1
//   count            : occupancy 0..DEPTH
//   full, empty      : occupancy flags
//   has_next         : at least two entries stored (head1 is valid)
module crossbar_seq_fifo
  import crossbar_seq_pkg::*;
#(
  parameter int EW    = DEF_NOUT + DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [EW-1:0]             push_data,
  input  logic                      pop,
  output logic [EW-1:0]             head,
  output logic [EW-1:0]             head1,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      has_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign has_next = (count_q >= CW'(2));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates everything read from it.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign head1 = mem_q[rd_ptr_q + AW'(1)];
  assign count = count_q;

endmodule

// File: rtl/crossbar_route_sequencer.sv
// Crossbar route sequencer: queues {dest, data} requests and plays them
// onto a crossbar, changing the select mask only after a one-cycle settle
// (SETUP) and streaming same-destination entries back to back.
// Ports:
//   clock, reset               : clock, synchronous active-low reset
//   io_in_valid/ready/dest/data: upstream request (ready = FIFO not full)
//   io_select                  : crossbar select mask
//   io_data                    : payload at the crossbar input (FIFO head)
//   io_out_valid/io_out_ready  : per-output handshake
//   io_err                     : sticky illegal-destination flag
//   io_count                   : FIFO occupancy
// Macro CROSSBAR_SEQ_BCAST_EN: multi-bit destinations are legal and each
// selected port completes independently; without it only one-hot
// destinations are legal and a single handshake completes an entry.
module crossbar_route_sequencer
  import crossbar_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NOUT  = DEF_NOUT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [NOUT-1:0]        io_in_dest,
  input  logic [WIDTH-1:0]       io_in_data,
  output logic [NOUT-1:0]        io_select,
  output logic [WIDTH-1:0]       io_data,
  output logic [NOUT-1:0]        io_out_valid,
  input  logic [NOUT-1:0]        io_out_ready,
  output logic                   io_err,
  output logic [$clog2(DEPTH):0] io_count
);

  localparam int EW = NOUT + WIDTH;

  state_e            state_q, state_d;
  logic [NOUT-1:0]   sel_q, sel_d;
  logic              err_q, err_d;
`ifdef CROSSBAR_SEQ_BCAST_EN
  logic [NOUT-1:0]   done_q, done_d;
`endif

  logic [EW-1:0]     head, head1;
  logic [NOUT-1:0]   head_dest, head1_dest;
  logic [WIDTH-1:0]  head_data;
  logic              unused_head1_data;
  logic              full, empty, has_next;
  logic              accept, dest_legal, push, pop;
  logic [NOUT-1:0]   out_valid, hs;
  logic              all_done;

  // Request side: ready is purely !full, so a full FIFO never takes a
  // request even on a pop cycle. Illegal requests are accepted and dropped.
`ifdef CROSSBAR_SEQ_BCAST_EN
  assign dest_legal = |io_in_dest;
`else
  assign dest_legal = $onehot(io_in_dest);
`endif
  assign accept = io_in_valid & ~full;
  assign push   = accept & dest_legal;

  crossbar_seq_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({io_in_dest, io_in_data}),
    .pop       (pop),
    .head      (head),
    .head1     (head1),
    .count     (io_count),
    .full      (full),
    .empty     (empty),
    .has_next  (has_next)
  );

  assign head_dest         = head[EW-1:WIDTH];
  assign head_data         = head[WIDTH-1:0];
  assign head1_dest        = head1[EW-1:WIDTH];
  assign unused_head1_data = ^head1[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    err_d     = err_q | (accept & ~dest_legal);
    pop       = 1'b0;
    out_valid = '0;
    hs        = '0;
    all_done  = 1'b0;
`ifdef CROSSBAR_SEQ_BCAST_EN
    done_d    = done_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_dest == sel_q) begin
            state_d = XFER;
          end else begin
            sel_d   = head_dest;
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = XFER;
      XFER: begin
`ifdef CROSSBAR_SEQ_BCAST_EN
        out_valid = sel_q & ~done_q;
        hs        = out_valid & io_out_ready;
        all_done  = ((done_q | hs) == sel_q);
        done_d    = all_done ? '0 : (done_q | hs);
`else
        out_valid = sel_q;
        hs        = out_valid & io_out_ready;
        all_done  = |hs;
`endif
        if (all_done) begin
          pop = 1'b1;
          // head1 is the entry that becomes head after this pop.
          if (!has_next) begin
            state_d = IDLE;
          end else if (head1_dest != sel_q) begin
            sel_d   = head1_dest;
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
`ifdef CROSSBAR_SEQ_BCAST_EN
      done_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
`ifdef CROSSBAR_SEQ_BCAST_EN
      done_q  <= done_d;
`endif
    end
  end

  assign io_in_ready  = ~full;
  assign io_select    = sel_q;
  assign io_data      = head_data;
  assign io_out_valid = out_valid;
  assign io_err       = err_q;

endmodule

// File: tb/tb_crossbar_route_sequencer.sv
// Self-checking bench for crossbar_route_sequencer (default parameters).
// A queue-based reference model tracks accepted legal requests, per-port
// completion of the head entry, and the sticky error flag; directed tasks
// add cycle-exact latency and SETUP-insertion checks.
module tb_crossbar_route_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NOUT  = 2;
`ifdef CROSSBAR_SEQ_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             io_in_valid = 1'b0;
  logic             io_in_ready;
  logic [NOUT-1:0]  io_in_dest = '0;
  logic [WIDTH-1:0] io_in_data = '0;
  logic [NOUT-1:0]  io_select;
  logic [WIDTH-1:0] io_data;
  logic [NOUT-1:0]  io_out_valid;
  logic [NOUT-1:0]  io_out_ready = '0;
  logic             io_err;
  logic [2:0]       io_count;

  crossbar_route_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOUT(NOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_dest   (io_in_dest),
    .io_in_data   (io_in_data),
    .io_select    (io_select),
    .io_data      (io_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_err       (io_err),
    .io_count     (io_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NOUT-1:0]  dest;
    logic [WIDTH-1:0] data;
  } ent_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  ent_t q[$];
  logic [NOUT-1:0] mdone = '0;
  bit merr = 1'b0;
  logic [NOUT-1:0] hs_s;

  function automatic bit legal(input logic [NOUT-1:0] d);
    return (d != '0) && (BCAST || $countones(d) == 1);
  endfunction

  // Check outputs against the model, advance the model by what happens at
  // the coming edge, then step past the edge.
  task automatic tick();
    logic [NOUT-1:0] ov;
    bit acc;
    ov   = io_out_valid;
    hs_s = io_out_valid & io_out_ready;
    acc  = io_in_valid && io_in_ready;
    total++;
    if (io_count !== 3'(q.size())) begin
      bad++; $display("FAIL count cyc=%0d got=%0d want=%0d", cyc, io_count, q.size());
    end
    total++;
    if (io_in_ready !== (q.size() < DEPTH)) begin
      bad++; $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, io_in_ready, q.size() < DEPTH);
    end
    total++;
    if (io_err !== merr) begin
      bad++; $display("FAIL err cyc=%0d got=%b want=%b", cyc, io_err, merr);
    end
    if (q.size() == 0) begin
      total++;
      if (ov !== '0) begin
        bad++; $display("FAIL valid_empty cyc=%0d got=%b want=00", cyc, ov);
      end
    end else if (ov !== '0) begin
      total++;
      if (ov !== (q[0].dest & ~mdone) || io_select !== q[0].dest || io_data !== q[0].data) begin
        bad++;
        $display("FAIL xfer cyc=%0d valid=%b sel=%b data=%h want valid=%b sel=%b data=%h",
                 cyc, ov, io_select, io_data, q[0].dest & ~mdone, q[0].dest, q[0].data);
      end
    end
    if (hs_s != '0 && q.size() > 0) begin
      mdone = mdone | hs_s;
      if (mdone == q[0].dest) begin
        void'(q.pop_front());
        mdone = '0;
      end
    end
    if (acc) begin
      if (legal(io_in_dest)) q.push_back('{io_in_dest, io_in_data});
      else merr = 1'b1;
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    io_in_valid = 1'b0;
    @(posedge clock); #1;
    cyc++;
    q.delete();
    mdone = '0;
    merr  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    reset = 1'b1;
    total++;
    if (io_in_ready !== 1'b1 || io_count !== 3'd0 || io_out_valid !== 2'b00 ||
        io_select !== 2'b00 || io_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state rdy=%b cnt=%0d valid=%b sel=%b err=%b want 1 0 00 00 0",
               io_in_ready, io_count, io_out_valid, io_select, io_err);
    end
  endtask

  task automatic test_single();
    io_out_ready = 2'b11;
    io_in_valid = 1'b1; io_in_dest = 2'b01; io_in_data = 8'hA5;
    tick();
    io_in_valid = 1'b0;
    total++;
    if (io_out_valid !== 2'b00) begin
      bad++; $display("FAIL single_t1 valid=%b want=00", io_out_valid);
    end
    tick();
    total++;
    if (io_out_valid !== 2'b00 || io_select !== 2'b01) begin
      bad++; $display("FAIL single_setup valid=%b sel=%b want 00 01", io_out_valid, io_select);
    end
    tick();
    total++;
    if (io_out_valid !== 2'b01 || io_data !== 8'hA5 || io_select !== 2'b01) begin
      bad++; $display("FAIL single_xfer valid=%b data=%h sel=%b want 01 a5 01", io_out_valid, io_data, io_select);
    end
    tick();
    total++;
    if (io_count !== 3'd0 || io_out_valid !== 2'b00) begin
      bad++; $display("FAIL single_drain cnt=%0d valid=%b want 0 00", io_count, io_out_valid);
    end
  endtask

  task automatic test_fill();
    int hc[$];
    io_out_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      io_in_valid = 1'b1; io_in_dest = 2'b01; io_in_data = 8'($urandom);
      tick();
    end
    io_in_data = 8'($urandom);
    total++;
    if (io_in_ready !== 1'b0 || io_count !== 3'd4) begin
      bad++; $display("FAIL fill_full rdy=%b cnt=%0d want 0 4", io_in_ready, io_count);
    end
    tick();
    io_in_valid = 1'b0;
    io_out_ready = 2'b11;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (hs_s != '0) hc.push_back(cyc);
    end
    total++;
    if (hc.size() != 4 || (hc[hc.size()-1] - hc[0]) != 3) begin
      bad++; $display("FAIL fill_stream transfers=%0d span=%0d want 4 3", hc.size(),
                      hc.size() > 0 ? hc[hc.size()-1] - hc[0] : -1);
    end
  endtask

  task automatic test_alternate();
    int hc[$];
    int k;
    bit sent;
    k = 0;
    io_out_ready = 2'b11;
    for (int c = 0; c < 40; c++) begin
      if (k < 6) begin
        io_in_valid = 1'b1;
        io_in_dest  = (k % 2 == 0) ? 2'b01 : 2'b10;
        io_in_data  = 8'($urandom);
      end else begin
        io_in_valid = 1'b0;
      end
      sent = (k < 6) && io_in_ready;
      tick();
      if (sent) k++;
      if (hs_s != '0) hc.push_back(cyc);
    end
    total++;
    if (hc.size() != 6) begin
      bad++; $display("FAIL alt_count transfers=%0d want=6", hc.size());
    end
    for (int i = 1; i < hc.size(); i++) begin
      total++;
      if (hc[i] - hc[i-1] != 2) begin
        bad++; $display("FAIL alt_setup idx=%0d gap=%0d want=2", i, hc[i] - hc[i-1]);
      end
    end
  endtask

  task automatic test_illegal();
    io_out_ready = 2'b11;
    io_in_valid = 1'b1; io_in_dest = 2'b00; io_in_data = 8'h5A;
    tick();
    io_in_valid = 1'b0;
    total++;
    if (io_err !== 1'b1 || io_count !== 3'd0) begin
      bad++; $display("FAIL illegal_dest err=%b cnt=%0d want 1 0", io_err, io_count);
    end
    for (int i = 0; i < 6; i++) begin
      io_in_valid = 1'($urandom_range(0, 1));
      io_in_dest  = (i % 2 == 0) ? 2'b10 : 2'b01;
      io_in_data  = 8'($urandom);
      tick();
    end
    io_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (io_err !== 1'b1) begin
      bad++; $display("FAIL err_sticky err=%b want=1", io_err);
    end
  endtask

  task automatic test_bcast();
    int w;
    do_reset();
    reset = 1'b1;
    io_out_ready = 2'b01;
    io_in_valid = 1'b1; io_in_dest = 2'b11; io_in_data = 8'h3C;
    tick();
    io_in_valid = 1'b0;
`ifdef CROSSBAR_SEQ_BCAST_EN
    w = 0;
    while (io_out_valid === 2'b00 && w < 10) begin tick(); w++; end
    total++;
    if (io_out_valid !== 2'b11 || w != 2) begin
      bad++; $display("FAIL bcast_start valid=%b wait=%0d want 11 2", io_out_valid, w);
    end
    tick();
    total++;
    if (io_out_valid !== 2'b10) begin
      bad++; $display("FAIL bcast_partial valid=%b want=10", io_out_valid);
    end
    tick();
    tick();
    io_out_ready = 2'b11;
    total++;
    if (io_out_valid !== 2'b10 || io_count !== 3'd1) begin
      bad++; $display("FAIL bcast_hold valid=%b cnt=%0d want 10 1", io_out_valid, io_count);
    end
    tick();
    total++;
    if (io_out_valid !== 2'b00 || io_count !== 3'd0) begin
      bad++; $display("FAIL bcast_pop valid=%b cnt=%0d want 00 0", io_out_valid, io_count);
    end
`else
    w = 0;
    for (int i = 0; i < 4; i++) begin tick(); w++; end
    total++;
    if (io_err !== 1'b1 || io_count !== 3'd0 || io_out_valid !== 2'b00) begin
      bad++; $display("FAIL multi_dest_err err=%b cnt=%0d valid=%b want 1 0 00 (cycles %0d)",
                      io_err, io_count, io_out_valid, w);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    reset = 1'b1;
    io_out_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      io_in_valid = 1'b1; io_in_dest = 2'b10; io_in_data = 8'($urandom);
      tick();
    end
    io_in_valid = 1'b0;
    w = 0;
    while (io_out_valid === 2'b00 && w < 10) begin tick(); w++; end
    total++;
    if (io_out_valid !== 2'b10) begin
      bad++; $display("FAIL mid_xfer_reach valid=%b want=10", io_out_valid);
    end
    io_out_ready = 2'b00;
    do_reset();
    total++;
    if (io_count !== 3'd0 || io_out_valid !== 2'b00 || io_select !== 2'b00 || io_in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset cnt=%0d valid=%b sel=%b rdy=%b want 0 00 00 1",
                      io_count, io_out_valid, io_select, io_in_ready);
    end
    reset = 1'b1;
    io_out_ready = 2'b11;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_random();
    int w;
    for (int c = 0; c < 500; c++) begin
      io_in_valid  = 1'($urandom_range(0, 1));
      io_in_dest   = 2'($urandom_range(0, 3));
      io_in_data   = 8'($urandom);
      io_out_ready = 2'($urandom_range(0, 3));
      tick();
    end
    io_in_valid  = 1'b0;
    io_out_ready = 2'b11;
    w = 0;
    while (q.size() != 0 && w < 60) begin tick(); w++; end
    tick();
    total++;
    if (q.size() != 0 || io_count !== 3'd0 || io_out_valid !== 2'b00) begin
      bad++; $display("FAIL random_drain model=%0d cnt=%0d valid=%b want 0 0 00",
                      q.size(), io_count, io_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_alternate();
    test_illegal();
    test_bcast();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
